// File: rtl/serializer.sv
// serializer: transmit end of the single-wire self-test link.
// Frames each 28-bit payload as {4'b1010, payload} and shifts it out MSB
// first, one bit per t_clk, behind a one-deep holding register.
// Optional build macro SER_PARITY_EN appends an even-parity bit
// (33-bit frame); without it the frame is 32 bits and no parity logic exists.
module serializer #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic        t_clk,
  input  logic        rst_n,
  input  logic [27:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        data_out,
  output logic        busy,
  output logic        frame_done
);

`ifdef SER_PARITY_EN
  localparam int unsigned FRAME_LEN = 33;
`else
  localparam int unsigned FRAME_LEN = 32;
`endif

  localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);
  localparam logic [5:0] PRE_LAST = 6'(FRAME_LEN - 2);
  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);
  localparam bit         HAS_GAP  = (IDLE_GAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t               state;
  logic [27:0]          hold;
  logic                 hold_full;
  // MSB of the frame goes straight to data_out on load, so the shifter
  // only keeps the remaining FRAME_LEN-1 bits.
  logic [FRAME_LEN-2:0] shreg;
  logic [5:0]           bit_cnt;
  logic [3:0]           gap_cnt;
  logic [FRAME_LEN-1:0] frame_word;
  logic                 last_bit;
  logic                 load;

  assign tx_ready = !hold_full;

  // Frame assembly from the holding register
  always_comb begin
`ifdef SER_PARITY_EN
    frame_word = {4'b1010, hold, ^hold};
`else
    frame_word = {4'b1010, hold};
`endif
  end

  // Decide when the held word moves into the shifter
  always_comb begin
    last_bit = (bit_cnt == LAST_BIT);
    load     = 1'b0;
    case (state)
      ST_IDLE:  load = hold_full;
      ST_SHIFT: load = hold_full && last_bit && !HAS_GAP;
      ST_GAP:   load = hold_full && (gap_cnt == GAP_LAST);
      default:  load = 1'b0;
    endcase
  end

  // One-deep holding register; never overwritten while full
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame FSM with registered line, busy and frame_done
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data_out   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (load) begin
      state      <= ST_SHIFT;
      shreg      <= frame_word[FRAME_LEN-2:0];
      data_out   <= frame_word[FRAME_LEN-1];
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_out   <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            data_out   <= 1'b0;
            gap_cnt    <= '0;
            if (HAS_GAP) begin
              state <= ST_GAP;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            shreg      <= {shreg[FRAME_LEN-3:0], 1'b0};
            data_out   <= shreg[FRAME_LEN-2];
            bit_cnt    <= bit_cnt + 6'd1;
            frame_done <= (bit_cnt == PRE_LAST);
          end
        end
        ST_GAP: begin
          data_out   <= 1'b0;
          frame_done <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          data_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed bench for serializer (IDLE_GAP=1 and IDLE_GAP=0 instances).
module tb_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif
  localparam logic [63:0] FULL = (64'd1 << FL) - 64'd1;

  logic        t_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, data_out, busy, frame_done;
  logic [27:0] tx_data0 = '0;
  logic        tx_valid0 = 1'b0;
  logic        tx_ready0, data_out0, busy0, frame_done0;

  int checks = 0;
  int errors = 0;

  always #5 t_clk = ~t_clk;

  serializer #(.IDLE_GAP(1)) dut (
    .t_clk(t_clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  serializer #(.IDLE_GAP(0)) dut0 (
    .t_clk(t_clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .data_out(data_out0), .busy(busy0), .frame_done(frame_done0)
  );

  // Reference framing: preamble 1010, payload, optional even parity
  function automatic logic [63:0] framed(input logic [27:0] p);
`ifdef SER_PARITY_EN
    return {31'b0, 4'hA, p, ^p};
`else
    return {32'b0, 4'hA, p};
`endif
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  // Sample one full frame from the selected instance and compare bits,
  // frame_done position and busy; optionally drop tx_valid after sample drop_after.
  task automatic expect_frame(input int sel, input logic [63:0] exp, input int drop_after,
                              input string tag, output logic [63:0] rv);
    logic [63:0] act, fd, bz;
    act = '0; fd = '0; bz = '0; rv = '0;
    for (int i = 0; i < FL; i++) begin
      tick();
      act = {act[62:0], (sel != 0) ? data_out0 : data_out};
      fd  = {fd[62:0], (sel != 0) ? frame_done0 : frame_done};
      bz  = {bz[62:0], (sel != 0) ? busy0 : busy};
      rv  = {rv[62:0], (sel != 0) ? tx_ready0 : tx_ready};
      if (i == drop_after) begin
        if (sel != 0) tx_valid0 = 1'b0;
        else tx_valid = 1'b0;
      end
    end
    chk(act, exp, {tag, "_bits"});
    chk(fd, 64'd1, {tag, "_done"});
    chk(bz, FULL, {tag, "_busy"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rv, e1, ea5, ep1, ep3, act10, f;
    logic        q_exp[$];
    logic        q_act[$];
    logic        acc;
    int          acc_n, mis;

`ifdef SER_PARITY_EN
    e1  = 64'h142468ACE;
    ea5 = 64'h14B4B4B4A;
    ep1 = 64'h140000003;
    ep3 = 64'h140000006;
`else
    e1  = 64'hA1234567;
    ea5 = 64'hA5A5A5A5;
    ep1 = 64'hA0000001;
    ep3 = 64'hA0000003;
`endif

    // Reset state
    #12;
    chk(data_out, 1'b0, "rst_data");
    chk(busy, 1'b0, "rst_busy");
    chk(frame_done, 1'b0, "rst_done");
    chk(tx_ready, 1'b1, "rst_ready");
    chk(tx_ready0, 1'b1, "rst_ready0");
    #1 rst_n = 1'b1;
    tick();

    // Single word 1234567
    tx_data = 28'h1234567; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk(tx_ready, 1'b0, "t1_hold_full");
    expect_frame(0, e1, -1, "t1", rv);
    tick();
    chk({busy, data_out, frame_done}, 3'b100, "t1_gap");
    tick();
    chk({busy, data_out}, 2'b00, "t1_idle");

    // Two words with tx_valid held, one gap cycle between them
    tx_data = 28'h0000000; tx_valid = 1'b1;
    tick();
    tx_data = 28'hFFFFFFF;
    expect_frame(0, framed(28'h0000000), 1, "t2a", rv);
    chk(rv, 64'd1 << (FL - 1), "t2a_ready");
    tick();
    chk({busy, data_out, tx_ready}, 3'b100, "t2_gap");
    expect_frame(0, framed(28'hFFFFFFF), -1, "t2b", rv);
    chk(rv, FULL, "t2b_ready");
    tick();
    tick();
    chk(busy, 1'b0, "t2_idle");

    // IDLE_GAP=0: three back-to-back frames of 5A5A5A5
    tx_data0 = 28'h5A5A5A5; tx_valid0 = 1'b1;
    tick();
    expect_frame(1, ea5, -1, "t3a", rv);
    expect_frame(1, ea5, 1, "t3b", rv);
    expect_frame(1, ea5, -1, "t3c", rv);
    tick();
    chk({busy0, data_out0}, 2'b00, "t3_idle");

    // Reset at bit 10 with the hold register full
    tx_data = 28'hFFFFFFF; tx_valid = 1'b1;
    tick();
    tx_data = 28'h1111111;
    act10 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      act10 = {act10[62:0], data_out};
      if (i == 1) tx_valid = 1'b0;
    end
    chk(act10, 64'h2BF, "t4_first10");
    chk(tx_ready, 1'b0, "t4_hold_full");
    chk(data_out, 1'b1, "t4_pre_line");
    #2 rst_n = 1'b0;
    #1;
    chk({data_out, busy, frame_done, tx_ready}, 4'b0001, "t4_async_rst");
    #2 rst_n = 1'b1;
    tick();
    chk({data_out, busy, tx_ready}, 3'b001, "t4_hold_lost");
    tx_data = 28'h2468ACE; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    expect_frame(0, framed(28'h2468ACE), -1, "t4", rv);
    tick();
    tick();
    chk(busy, 1'b0, "t4_idle");

    // Payload 1 and 3 (parity 1 / 0 when parity is built in)
    tx_data = 28'h0000001; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    expect_frame(0, ep1, -1, "t5a", rv);
    tick();
    tick();
    tx_data = 28'h0000003; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    expect_frame(0, ep3, -1, "t5b", rv);
    tick();
    tick();
    chk(busy, 1'b0, "t5_idle");

    // Random valid gaps: busy-qualified bitstream equals framed inputs plus gap bits
    acc_n = 0;
    tx_data = 28'($urandom);
    for (int c = 0; c < 1200 && acc_n < 8; c++) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      acc = tx_valid && tx_ready;
      tick();
      if (acc) begin
        f = framed(tx_data);
        for (int b = FL - 1; b >= 0; b--) q_exp.push_back(f[b]);
        q_exp.push_back(1'b0);
        acc_n++;
        tx_data = 28'($urandom);
      end
      if (busy) q_act.push_back(data_out);
    end
    tx_valid = 1'b0;
    for (int c = 0; c < 2 * (FL + 2) + 4; c++) begin
      tick();
      if (busy) q_act.push_back(data_out);
    end
    chk(64'(acc_n), 64'd8, "t6_accepts");
    chk(64'(q_act.size()), 64'(q_exp.size()), "t6_len");
    mis = 0;
    for (int i = 0; i < q_act.size() && i < q_exp.size(); i++)
      if (q_act[i] !== q_exp[i]) mis++;
    chk(64'(mis), 64'd0, "t6_stream");
    chk(busy, 1'b0, "t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
Transmit end of the single-wire self-test link; the companion of the deserializer in self_test.
Accepts 28-bit payload words over a valid/ready handshake and sends each as a 32-bit frame, MSB first, one bit per t_clk.
Frame word = {4'b1010 preamble, payload[27:0]}. A matching deserializer presents it as four bytes; payload 28'h1234567 yields bytes A1,23,45,67.
A one-deep holding register lets the next word be accepted while the current frame is shifting.

Parameters:
IDLE_GAP, 1, number of idle cycles (line=0) forced between consecutive frames; 0 allows back-to-back frames; legal range 0..15

Ports:
t_clk  input  1  bit clock
rst_n  input  1  asynchronous, active-low reset
tx_data  input  28  payload word
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; transfer occurs on the edge where tx_valid && tx_ready
data_out  output  1  registered serial line, idle level 0
busy  output  1  frame or post-frame gap in progress
frame_done  output  1  single-cycle pulse, high while the last bit of a frame is on data_out

Behaviour:
- Reset (async, immediate): data_out=0, busy=0, frame_done=0, tx_ready=1; holding register emptied; shifter, counters and FSM cleared.
- Holding register: tx_ready = !hold_full (combinational from the register flag).
  - Accept on edge with tx_valid && tx_ready: capture tx_data, set hold_full.
  - hold_full clears on the edge the word moves into the shifter.
- Shifter: 32-bit (33 with parity); 6-bit bit counter.
- FSM states:
  - IDLE: data_out=0, busy=0. If hold_full, on the next edge: load shifter with {4'b1010, hold}, drive data_out=1 (frame MSB), clear hold_full, bit_cnt=0, go to SHIFT.
  - SHIFT: each edge shifts left and drives the next MSB; bit_cnt increments. frame_done=1 while bit_cnt == FRAME_LEN-1.
    - After the last bit, if IDLE_GAP>0: go to GAP with data_out=0, gap_cnt=0.
    - If IDLE_GAP==0 and hold_full: reload immediately; the next frame's first bit follows the previous last bit with no idle cycle.
    - Otherwise go to IDLE.
  - GAP: data_out=0, busy=1; gap_cnt increments. When gap_cnt == IDLE_GAP-1: load from hold if full (same as the IDLE load), else go to IDLE.
- busy=1 in SHIFT and GAP, and on the cycle a load occurs; 0 only in IDLE.
- Latency: word accepted at edge k with FSM in IDLE puts the first preamble bit on data_out after edge k+1. The last bit is on the line after edge k+32 (no parity).
- Throughput: one frame per FRAME_LEN+IDLE_GAP cycles when tx_valid is held high.
- Backpressure: with the shifter busy and hold full, tx_ready=0. tx_data is ignored until hold drains.
- The hold register is never overwritten while full.
- Payload content is not inspected; a 1010 pattern inside the payload is transmitted unchanged.
- Reset asserted mid-frame aborts the frame; data_out drops to 0 asynchronously and the pending hold word is lost.
- FRAME_LEN = 32, or 33 with parity.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: FRAME_LEN=33; an even-parity bit (XOR of payload[27:0]) is appended after payload bit 0. frame_done marks the parity bit. Used with a parity-aware deserializer variant.
- Undefined: FRAME_LEN=32; no parity bit; all parity logic absent.

Test Plan:
- Reset, then tx_data=28'h1234567 single pulse -> data_out after edges k+1..k+32 = bits of 32'hA1234567 MSB first; frame_done high exactly during bit 32; busy falls after IDLE_GAP cycles of 0.
- tx_data=28'h0000000 then 28'hFFFFFFF, tx_valid held high, IDLE_GAP=1 -> 1010+28 zeros, one 0 gap cycle, 1010+28 ones. tx_ready is low from the second accept until the second load.
- IDLE_GAP=0, three words 28'h5A5A5A5 back-to-back -> 96 contiguous bits, no idle cycle; a deserializer model recovers bytes A5,A5,A5,A5 per frame.
- rst_n pulsed low at bit 10 of a frame with hold full -> data_out=0 immediately; tx_ready=1, busy=0; the next accepted word is transmitted cleanly from its preamble.
- SER_PARITY_EN: payload 28'h0000001 -> 33 bits ending in parity 1; payload 28'h0000003 -> parity 0; frame_done aligned to the parity bit.
- tx_valid toggling with random gaps while busy -> no word dropped or duplicated; output bitstream equals the concatenated framed input sequence.
